// File: rtl/pll_scan_pkg.sv
// Shared constants and types for the PLL scan-chain responder model.
package pll_scan_pkg;

    localparam int SCAN_BITS  = 144;
    localparam int FIELD_BITS = 18;
    localparam int FIELD_M    = 1;
    localparam int FIELD_N    = 2;
    localparam int FIELD_C0   = 3;
    localparam int NUM_C      = 5;
    localparam int DIV_W      = 10;
    // Decoded fields: M, N, C0..C4
    localparam int NUM_DEC    = 2 + NUM_C;

    // One 18-bit counter field as laid out in the scan chain, MSB first.
    typedef struct packed {
        logic       bypass;
        logic [7:0] hi;
        logic       odd;
        logic [7:0] lo;
    } cnt_field_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } upd_state_t;

endpackage

// File: rtl/pll_cnt_decode.sv
// Turns one 18-bit PLL counter field into its divide factor.
// A zero hi/lo count means 256; bypass forces a factor of 1.
module pll_cnt_decode
    import pll_scan_pkg::*;
(
    input  logic [FIELD_BITS-1:0] field,
    output logic [DIV_W-1:0]      div
);

    cnt_field_t f;
    logic [DIV_W-1:0] hv;
    logic [DIV_W-1:0] lv;
    // The odd bit only shapes duty cycle, so it plays no part in the factor.
    logic odd_unused;

    assign f          = field;
    assign odd_unused = f.odd;

    // Sum of high and low phase counts, with 0 standing for 256.
    always_comb begin
        hv  = (f.hi == 8'd0) ? DIV_W'(256) : {2'b00, f.hi};
        lv  = (f.lo == 8'd0) ? DIV_W'(256) : {2'b00, f.lo};
        div = f.bypass ? DIV_W'(1) : (hv + lv);
    end

endmodule

// File: rtl/pll_scanchain_model.sv
// Responder end of the PLL dynamic-reconfiguration scan interface.
// Shifts scandata into a shadow chain, commits it on configupdate, raises
// scandone SCANDONE_LAT cycles later, models areset/lock, and decodes the
// committed image into M/N/C0..C4 divide factors.
// Optional: define PLL_SCAN_LEN_CHECK_EN to reject commits whose shift count
// since the previous commit is not exactly SCAN_BITS (flagged on scan_err).
module pll_scanchain_model
    import pll_scan_pkg::*;
#(
    parameter int SCAN_BITS    = 144,
    parameter int SCANDONE_LAT = 4,
    parameter int LOCK_LAT     = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        scanclkena,
    input  logic                        scandata,
    input  logic                        configupdate,
    input  logic                        areset,
    output logic                        scandone,
    output logic                        locked,
    output logic [SCAN_BITS-1:0]        active_cfg,
    output logic [DIV_W-1:0]            m_div,
    output logic [DIV_W-1:0]            n_div,
    output logic [NUM_C-1:0][DIV_W-1:0] c_div,
    output logic                        scan_err
);

    logic [SCAN_BITS-1:0] shadow;
    upd_state_t           state;
    logic [3:0]           lat_cnt;
    logic [7:0]           lock_cnt;
    logic                 commit_ok;

    logic [NUM_DEC-1:0][FIELD_BITS-1:0] fields;
    logic [NUM_DEC-1:0][DIV_W-1:0]      divs;

`ifdef PLL_SCAN_LEN_CHECK_EN
    logic [7:0] bit_cnt;
    logic       scan_err_q;

    assign commit_ok = (bit_cnt == 8'(SCAN_BITS));
    assign scan_err  = scan_err_q;

    // Count shifts since the last commit; a commit of the wrong length is refused.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bit_cnt    <= '0;
            scan_err_q <= 1'b0;
        end else if (configupdate) begin
            bit_cnt <= '0;
            if (!commit_ok) scan_err_q <= 1'b1;
        end else if (scanclkena && bit_cnt != 8'hFF) begin
            bit_cnt <= bit_cnt + 8'd1;
        end
    end
`else
    assign commit_ok = 1'b1;
    assign scan_err  = 1'b0;
`endif

    // Shadow chain: new bits enter at the top, so the first bit lands at bit 0.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)        shadow <= '0;
        else if (scanclkena) shadow <= {scandata, shadow[SCAN_BITS-1:1]};
    end

    // Commit copies the pre-shift shadow into the active image.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)                       active_cfg <= '0;
        else if (configupdate && commit_ok) active_cfg <= shadow;
    end

    // Update FSM: count out SCANDONE_LAT after each configupdate, then flag done.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            scandone <= 1'b0;
        end else begin
            if (scanclkena) scandone <= 1'b0;
            case (state)
                IDLE: ;
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        state    <= DONE;
                        scandone <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // A fresh configupdate always restarts the count, even mid-wait.
            if (configupdate) begin
                state    <= WAIT;
                lat_cnt  <= 4'(SCANDONE_LAT);
                scandone <= 1'b0;
            end
        end
    end

    // Lock model: areset holds the counter at LOCK_LAT; lock asserts when it drains.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (areset) begin
            lock_cnt <= 8'(LOCK_LAT);
            locked   <= 1'b0;
        end else if (lock_cnt != 8'd0) begin
            lock_cnt <= lock_cnt - 8'd1;
            if (lock_cnt == 8'd1) locked <= 1'b1;
        end
    end

    // Field 0 (loop filter / charge pump) is not decoded.
    assign fields = active_cfg[FIELD_BITS*(NUM_DEC+1)-1:FIELD_BITS];

    pll_cnt_decode u_dec [NUM_DEC-1:0] (
        .field (fields),
        .div   (divs)
    );

    assign m_div = divs[FIELD_M-1];
    assign n_div = divs[FIELD_N-1];
    assign c_div = divs[FIELD_C0-1 +: NUM_C];

endmodule
